// File: rtl/instruction_memory_pkg.sv
// Shared types and constants for the 8 x 12-bit instruction store.
package instruction_memory_pkg;
   localparam int IMEM_DEPTH  = 8;
   localparam int IMEM_WIDTH  = 12;
   localparam int IMEM_ADDR_W = 3;

   typedef logic [IMEM_WIDTH-1:0]  instr_t;
   typedef logic [IMEM_ADDR_W-1:0] imem_addr_t;
   typedef instr_t [IMEM_DEPTH-1:0] program_t;

   // Program image restored on reset: every word is a zero instruction.
   localparam program_t DEFAULT_PROGRAM = '0;
endpackage

// File: rtl/instruction_memory_write_ptr.sv
// imem_write_ptr: 3-bit wrapping load pointer, advances once per enabled clock.
module imem_write_ptr
   import instruction_memory_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output imem_addr_t ptr
);

   // Natural 3-bit overflow gives the modulo-8 wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   ptr <= '0;
      else if (en) ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/instruction_memory.sv
// instruction_memory: 8 x 12-bit instruction store, combinational read by
// index, sequential program load through an internal write pointer.
// Optional macro INSTR_MEM_WRITE_BYPASS_EN forwards new_instruction to out
// when the read index hits the word being loaded this cycle.
module instruction_memory
   import instruction_memory_pkg::*;
(
   input  imem_addr_t index,
   input  instr_t     new_instruction,
   input  logic       load,
   input  logic       clk,
   input  logic       reset,
   output instr_t     out
);

   localparam int DEPTH = IMEM_DEPTH;
   localparam int WIDTH = IMEM_WIDTH;

   program_t   mem;
   imem_addr_t wr_ptr;

   imem_write_ptr u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .en    (load),
      .ptr   (wr_ptr)
   );

   // Store one word at the load pointer; reset restores the default program.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     mem <= DEFAULT_PROGRAM;
      else if (load) mem[wr_ptr] <= new_instruction;
   end

   // Zero-latency read; index only ever selects, it never addresses writes.
`ifdef INSTR_MEM_WRITE_BYPASS_EN
   always_comb begin
      out = mem[index];
      if (load && !reset && (index == wr_ptr)) out = new_instruction;
   end
`else
   always_comb begin
      out = mem[index];
   end
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory with an array-based reference model.
module tb_instruction_memory;
   import instruction_memory_pkg::*;

`ifdef INSTR_MEM_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   imem_addr_t index = '0;
   instr_t     new_instruction = '0;
   logic       load = 1'b0;
   instr_t     out;

   int checks = 0;
   int errors = 0;
   bit armed = 1'b0;

   // Reference model: plain array plus integer pointer.
   logic [11:0] ref_mem [8];
   int          ref_ptr;

   instruction_memory dut (
      .index           (index),
      .new_instruction (new_instruction),
      .load            (load),
      .clk             (clk),
      .reset           (reset),
      .out             (out)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) ref_mem[i] = 12'h000;
         ref_ptr = 0;
      end else if (load) begin
         ref_mem[ref_ptr] = new_instruction;
         ref_ptr = (ref_ptr + 1) % 8;
      end
   end

   function automatic logic [11:0] ref_out();
      if (BYP && load && !reset && (int'(index) == ref_ptr)) return new_instruction;
      return ref_mem[index];
   endfunction

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s idx=%0d got %h want %h t=%0t", name, index, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (armed) chk("model", out, ref_out());
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset and zero sweep
      step();
      reset = 1'b0;
      armed = 1'b1;
      for (int i = 0; i < 8; i++) begin
         index = 3'(i);
         #1 chk("rst_zero", out, 12'h000);
         step();
      end

      // Load 0..7 while index parked at 7: writes must follow the pointer
      index = 3'd7;
      for (int i = 0; i < 8; i++) begin
         new_instruction = 12'(i);
         load = 1'b1;
         step();
      end
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         index = 3'(i);
         #1 chk("seq_load", out, 12'(i));
         step();
      end

      // Ninth load wraps to entry 0
      new_instruction = 12'hABC;
      load = 1'b1;
      step();
      load = 1'b0;
      index = 3'd0;
      #1 chk("wrap_e0", out, 12'hABC);
      for (int i = 1; i < 8; i++) begin
         index = 3'(i);
         #1 chk("wrap_keep", out, 12'(i));
      end
      step();

      // Mid-cycle asynchronous reset
      index = 3'd3;
      #1 chk("pre_rst", out, 12'h003);
      reset = 1'b1;
      #1 chk("async_rst", out, 12'h000);
      reset = 1'b0;
      step();
      new_instruction = 12'h055;
      load = 1'b1;
      step();
      load = 1'b0;
      index = 3'd0;
      #1 chk("post_rst_e0", out, 12'h055);
      index = 3'd1;
      #1 chk("post_rst_e1", out, 12'h000);
      step();

      // Reset and load on the same edge: reset wins
      reset = 1'b1;
      load = 1'b1;
      new_instruction = 12'hFFF;
      step();
      reset = 1'b0;
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         index = 3'(i);
         #1 chk("rst_wins", out, 12'h000);
      end
      step();

      // Read-during-write at index == pointer (pointer must still be 0)
      index = 3'd0;
      new_instruction = 12'h321;
      load = 1'b1;
      #1 chk("rdw_pre", out, BYP ? 12'h321 : 12'h000);
      step();
      chk("rdw_post", out, 12'h321);
      load = 1'b0;
      index = 3'd1;
      #1 chk("rdw_e1", out, 12'h000);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
